// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared widths and trace record layout for commit_trace_buffer
package trace_pkg;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int REGIDX_W = 5;

    localparam int CYC_LSB   = 0;
    localparam int CYC_W     = XLEN;
    localparam int INSTR_LSB = CYC_LSB + CYC_W;
    localparam int INSTR_W   = XLEN;
    localparam int RD_LSB    = INSTR_LSB + INSTR_W;
    localparam int RD_W      = REGIDX_W;
    localparam int VALUE_LSB = RD_LSB + RD_W;
    localparam int VALUE_W   = XLEN;
    localparam int MULTI_LSB = VALUE_LSB + VALUE_W;
    localparam int REC_W     = MULTI_LSB + 1;

    function automatic logic [XLEN-1:0] reg_at(input logic [NREGS*XLEN-1:0] flat, input int idx);
        return flat[idx*XLEN +: XLEN];
    endfunction

    function automatic logic [REC_W-1:0] pack_rec(
        input logic [CYC_W-1:0]   cycle,
        input logic [INSTR_W-1:0] instr,
        input logic [RD_W-1:0]    rd,
        input logic [VALUE_W-1:0] value,
        input logic               multi
    );
        logic [REC_W-1:0] r;
        r = '0;
        r[CYC_LSB +: CYC_W]     = cycle;
        r[INSTR_LSB +: INSTR_W] = instr;
        r[RD_LSB +: RD_W]       = rd;
        r[VALUE_LSB +: VALUE_W] = value;
        r[MULTI_LSB]            = multi;
        return r;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// rtl/commit_trace_buffer_if.sv - valid/ready trace record stream toward the sink
interface commit_trace_buffer_if;
    import trace_pkg::*;

    logic                trace_valid;
    logic                trace_ready;
    logic [XLEN-1:0]     trace_cycle;
    logic [XLEN-1:0]     trace_instr;
    logic [REGIDX_W-1:0] trace_rd;
    logic [XLEN-1:0]     trace_value;
    logic                trace_multi;

    modport master (
        output trace_valid, trace_cycle, trace_instr, trace_rd, trace_value, trace_multi,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_cycle, trace_instr, trace_rd, trace_value, trace_multi,
        output trace_ready
    );

endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - show-ahead synchronous FIFO with occupancy count
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_pop;
    logic             do_push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];
    assign count    = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - register-change detector feeding a queued trace record stream
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LOG_ALL = 0,
    parameter int OVF_W   = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture_en,
    input  logic [XLEN-1:0]       instr,
    input  logic [NREGS*XLEN-1:0] regs_flat,
    commit_trace_buffer_if.master trace,
    output logic [CNT_W-1:0]      fifo_count,
    output logic [OVF_W-1:0]      overflow_cnt
);

    logic [XLEN-1:0]     shadow [1:NREGS-1];
    logic [NREGS-1:0]    change_mask;
    logic [REGIDX_W-1:0] rec_rd;
    logic [XLEN-1:0]     rec_value;
    logic                rec_multi;
    logic                seen;
    logic [XLEN-1:0]     cycle_q;
    logic [XLEN-1:0]     cycle_next;
    logic [OVF_W-1:0]    overflow_q;
    logic                push;
    logic                pop;
    logic [REC_W-1:0]    head_rec;
    logic                fifo_full;
    logic                fifo_empty;
    logic                unused_x0;

    assign unused_x0 = ^regs_flat[XLEN-1:0];

    // Shadow follows the register file every edge so a disabled gap never shows up as a diff.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREGS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                shadow[i] <= reg_at(regs_flat, i);
            end
        end
    end

    always_comb begin
        change_mask = '0;
        for (int i = 1; i < NREGS; i++) begin
            change_mask[i] = (reg_at(regs_flat, i) != shadow[i]);
        end
    end

    // Scan high to low so the lowest changed index is the last one written.
    always_comb begin
        rec_rd    = '0;
        rec_multi = 1'b0;
        seen      = 1'b0;
        for (int i = NREGS - 1; i >= 1; i--) begin
            if (change_mask[i]) begin
                rec_rd    = REGIDX_W'(i);
                rec_multi = rec_multi | seen;
                seen      = 1'b1;
            end
        end
    end

    assign rec_value  = (rec_rd == '0) ? '0 : reg_at(regs_flat, int'(rec_rd));
    assign cycle_next = cycle_q + 1'b1;
    assign push       = capture_en && ((|change_mask) || (LOG_ALL != 0));
    assign pop        = trace.trace_valid && trace.trace_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
        end else if (capture_en) begin
            cycle_q <= cycle_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= '0;
        end else if (push && fifo_full && !pop && (overflow_q != {OVF_W{1'b1}})) begin
            overflow_q <= overflow_q + 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (pack_rec(cycle_next, instr, rec_rd, rec_value, rec_multi)),
        .pop       (pop),
        .pop_data  (head_rec),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Fields read zero whenever nothing is queued, including straight out of reset.
    assign trace.trace_valid = !fifo_empty;
    assign trace.trace_cycle = fifo_empty ? '0 : head_rec[CYC_LSB +: CYC_W];
    assign trace.trace_instr = fifo_empty ? '0 : head_rec[INSTR_LSB +: INSTR_W];
    assign trace.trace_rd    = fifo_empty ? '0 : head_rec[RD_LSB +: RD_W];
    assign trace.trace_value = fifo_empty ? '0 : head_rec[VALUE_LSB +: VALUE_W];
    assign trace.trace_multi = fifo_empty ? 1'b0 : head_rec[MULTI_LSB];
    assign overflow_cnt      = overflow_q;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Watches the CPU architectural state each clock: the 32 register-file values and the current instruction.
- Detects which register changed, timestamps the change with a cycle count, and queues a trace record in a small FIFO.
- Drains records over a valid/ready interface to a trace sink: bench logger, UART dumper or checker.
- Sits directly downstream of the CPU's register/instruction observation ports and replaces per-cycle full-register-file dumps with compact change records.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, at least 2).
- LOG_ALL, 0, 1 = push a record every enabled cycle even when no register changed.
- OVF_W, 16, width of the saturating overflow counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- capture_en  in  1  sample and log this cycle.
- instr  in  32  CPU currentInstruction.
- regs_flat  in  1024  register file, x(i) at bits [32*i+31 : 32*i].
- trace_valid  out  1  head record available.
- trace_ready  in  1  sink accepts the head record.
- trace_cycle  out  32  cycle number of the record.
- trace_instr  out  32  instruction of that cycle.
- trace_rd  out  5  lowest-indexed changed register (0 = none).
- trace_value  out  32  new value of trace_rd.
- trace_multi  out  1  more than one register changed that cycle.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.
- overflow_cnt  out  OVF_W  records dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync-safe deassert) clears:
  - shadow register copy to 0;
  - cycle counter to 0;
  - FIFO to empty;
  - overflow_cnt to 0.
  - All trace_* outputs read 0, trace_valid = 0, fifo_count = 0.
- Shadow copy: updated from regs_flat on every rising edge, regardless of capture_en, so re-enabling never reports stale diffs.
- Cycle counter: increments on every edge with capture_en = 1 and wraps at 2^32. The stored trace_cycle is the post-increment value, so the first enabled cycle is 1.
- Change mask: bit i = (x(i) != shadow(i)) for i = 1..31. x0 is never compared.
- Record generation (same edge, using the pre-update shadow):
  - rd = lowest set bit of the mask, else 0;
  - value = x(rd), or 0 when rd = 0;
  - multi = popcount(mask) > 1.
- Push condition: capture_en AND (mask != 0 OR LOG_ALL).
- FIFO: show-ahead. trace_* is driven combinationally from the head entry. A pop occurs on trace_valid AND trace_ready at the clock edge.
- Push while full:
  - with a simultaneous pop, both occur and the count is unchanged;
  - without a pop, the record is dropped and overflow_cnt increments, saturating at all-ones.
- Pop when empty: ignored.
- Push into empty: trace_valid rises the cycle after the edge (1-cycle latency). No fall-through on the same edge.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by count.
- Reset mid-drain: trace_valid drops immediately (asynchronously). Queued records are lost.

Decomposition:
- Shared package trace_pkg:
  - XLEN = 32, NREGS = 32, REGIDX_W = 5;
  - record field offsets and widths (cycle, instr, rd, value, multi; 102 bits total).
- One sub-module: trace_fifo, a parameterised synchronous show-ahead FIFO with count, full and empty outputs and the same clk/reset convention.
- Change detection, priority encoder, popcount>1, cycle counter and overflow counter live in commit_trace_buffer.

Test Plan:
1. Reset low, then high; regs all 0; capture_en = 1 for 3 cycles -> fifo_count = 0, trace_valid = 0, overflow_cnt = 0.
2. On enabled cycle 2, x5 = 0x0000000A, instr = 0x00A00293 -> one record: trace_cycle = 2, trace_instr = 0x00A00293, trace_rd = 5, trace_value = 0x0000000A, trace_multi = 0.
3. x3 = 0x11 and x7 = 0x22 change on the same edge -> trace_rd = 3, trace_value = 0x11, trace_multi = 1. Also: only x0 bits toggled -> no record.
4. DEPTH = 8, trace_ready = 0, 10 consecutive single-register changes -> fifo_count = 8, overflow_cnt = 2, first drained record is the first change. Then a change while full with trace_ready = 1 -> count stays 8, overflow_cnt stays 2.
5. capture_en = 0 while x9 changes to 0x5, then capture_en = 1 with no further change -> no record, and the cycle counter resumes without counting the disabled cycles. With LOG_ALL = 1: a record with rd = 0, value = 0.
6. Assert reset with 4 records queued mid-drain -> trace_valid = 0 immediately. After release: fifo_count = 0, first new record has trace_cycle = 1.
